// File: rtl/game_timer.sv
// game_timer: BCD round clock with programmable ceiling, up/down counting,
// load, saturate-or-wrap terminal behaviour, expiry pulse and low-time warning.
module game_timer #(
  parameter int unsigned MAX_SECONDS  = 59,
  parameter int unsigned WRAP         = 0,
  parameter int unsigned WARN_SECONDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       pause,
  input  logic       count_down,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       done,
  output logic       expire,
  output logic       warn
);

  // Ceiling and warning thresholds clamped to two BCD digits.
  localparam int unsigned MAX_CLAMP  = (MAX_SECONDS > 99) ? 99 : MAX_SECONDS;
  localparam int unsigned WARN_CLAMP = (WARN_SECONDS > 99) ? 99 : WARN_SECONDS;

  // Packed BCD forms; for valid BCD, numeric order equals 8-bit unsigned order.
  localparam logic [7:0] MAX_BCD  = {4'(MAX_CLAMP / 10), 4'(MAX_CLAMP % 10)};
  localparam logic [7:0] WARN_BCD = {4'(WARN_CLAMP / 10), 4'(WARN_CLAMP % 10)};
  localparam logic [7:0] ZERO_BCD = 8'h00;
  localparam logic       WRAP_EN  = (WRAP != 0);

  logic [7:0] cur;
  logic [7:0] load_val;
  logic [7:0] inc_val;
  logic [7:0] dec_val;
  logic [7:0] nxt;
  logic       done_nxt;
  logic       expire_nxt;
  logic       warn_nxt;
  logic       count_tick;
  logic       at_max;
  logic       at_zero;

  assign cur        = {tens, ones};
  assign count_tick = tick & ~pause & ~done;
  assign at_max     = (cur == MAX_BCD);
  assign at_zero    = (cur == ZERO_BCD);

  // Load value: any non-BCD digit or out-of-range value loads the ceiling.
  always_comb begin
    load_val = {load_tens, load_ones};
    if ((load_tens > 4'd9) || (load_ones > 4'd9) || ({load_tens, load_ones} > MAX_BCD)) begin
      load_val = MAX_BCD;
    end
  end

  // BCD increment with ones-to-tens carry.
  always_comb begin
    inc_val = {tens, ones + 4'd1};
    if (ones == 4'd9) begin
      inc_val = {tens + 4'd1, 4'd0};
    end
  end

  // BCD decrement with ones-from-tens borrow.
  always_comb begin
    dec_val = {tens, ones - 4'd1};
    if (ones == 4'd0) begin
      dec_val = {tens - 4'd1, 4'd9};
    end
  end

  // Next value, terminal flag and expiry pulse; load beats a counting tick.
  always_comb begin
    nxt        = cur;
    done_nxt   = done;
    expire_nxt = 1'b0;
    if (load) begin
      nxt      = load_val;
      done_nxt = 1'b0;
    end else if (count_tick) begin
      if (count_down) begin
        if (at_zero) begin
          expire_nxt = 1'b1;
          if (WRAP_EN) begin
            nxt = MAX_BCD;
          end else begin
            done_nxt = 1'b1;
          end
        end else begin
          nxt = dec_val;
          if (!WRAP_EN && (dec_val == ZERO_BCD)) begin
            done_nxt   = 1'b1;
            expire_nxt = 1'b1;
          end
        end
      end else begin
        if (at_max) begin
          expire_nxt = 1'b1;
          if (WRAP_EN) begin
            nxt = ZERO_BCD;
          end else begin
            done_nxt = 1'b1;
          end
        end else begin
          nxt = inc_val;
          if (!WRAP_EN && (inc_val == MAX_BCD)) begin
            done_nxt   = 1'b1;
            expire_nxt = 1'b1;
          end
        end
      end
    end
  end

  // Warning follows the next value so it lines up with the digits.
  always_comb begin
    warn_nxt = 1'b0;
    if (count_down && (nxt != ZERO_BCD) && (nxt <= WARN_BCD)) begin
      warn_nxt = 1'b1;
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens   <= 4'd0;
      ones   <= 4'd0;
      done   <= 1'b0;
      expire <= 1'b0;
      warn   <= 1'b0;
    end else begin
      tens   <= nxt[7:4];
      ones   <= nxt[3:0];
      done   <= done_nxt;
      expire <= expire_nxt;
      warn   <= warn_nxt;
    end
  end

endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: two timer configurations driven in lockstep and compared
// every cycle against an integer reference model, plus directed spot checks.
module tb_game_timer;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       pause;
  logic       count_down;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;

  logic [3:0] tens0, ones0, tens1, ones1;
  logic       done0, expire0, warn0, done1, expire1, warn1;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state per instance: 0 = MAX 59 saturating, 1 = MAX 39 wrapping.
  int maxv [2] = '{59, 39};
  int wrapv[2] = '{0, 1};
  int warnv[2] = '{10, 10};
  int mv   [2];
  bit md   [2];
  bit me   [2];
  bit mw   [2];

  game_timer #(.MAX_SECONDS(59), .WRAP(0), .WARN_SECONDS(10)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .count_down(count_down),
    .load(load), .load_tens(load_tens), .load_ones(load_ones),
    .tens(tens0), .ones(ones0), .done(done0), .expire(expire0), .warn(warn0)
  );

  game_timer #(.MAX_SECONDS(39), .WRAP(1), .WARN_SECONDS(10)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .count_down(count_down),
    .load(load), .load_tens(load_tens), .load_ones(load_ones),
    .tens(tens1), .ones(ones1), .done(done1), .expire(expire1), .warn(warn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int lv;
      int term;
      me[k] = 1'b0;
      if (rst) begin
        mv[k] = 0;
        md[k] = 1'b0;
      end else if (load) begin
        lv = int'(load_tens) * 10 + int'(load_ones);
        if (load_tens > 4'd9 || load_ones > 4'd9 || lv > maxv[k]) lv = maxv[k];
        mv[k] = lv;
        md[k] = 1'b0;
      end else if (tick && !pause && !md[k]) begin
        term = count_down ? 0 : maxv[k];
        if (mv[k] == term) begin
          me[k] = 1'b1;
          if (wrapv[k] != 0) mv[k] = count_down ? maxv[k] : 0;
          else md[k] = 1'b1;
        end else begin
          mv[k] = count_down ? mv[k] - 1 : mv[k] + 1;
          if (wrapv[k] == 0 && mv[k] == term) begin
            md[k] = 1'b1;
            me[k] = 1'b1;
          end
        end
      end
      mw[k] = !rst && count_down && mv[k] >= 1 && mv[k] <= warnv[k];
    end
  endtask

  task automatic check_all();
    check("i0_tens",   8'(tens0),   8'(mv[0] / 10));
    check("i0_ones",   8'(ones0),   8'(mv[0] % 10));
    check("i0_done",   8'(done0),   8'(md[0]));
    check("i0_expire", 8'(expire0), 8'(me[0]));
    check("i0_warn",   8'(warn0),   8'(mw[0]));
    check("i1_tens",   8'(tens1),   8'(mv[1] / 10));
    check("i1_ones",   8'(ones1),   8'(mv[1] % 10));
    check("i1_done",   8'(done1),   8'(md[1]));
    check("i1_expire", 8'(expire1), 8'(me[1]));
    check("i1_warn",   8'(warn1),   8'(mw[1]));
  endtask

  // One clock: update model, let the edge pass, sample after it.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    load = 1'b1; load_tens = t; load_ones = o;
    cycle();
    load = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    tick = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; pause = 1'b0; count_down = 1'b0;
    load = 1'b0; load_tens = 4'd0; load_ones = 4'd0;
    for (int k = 0; k < 2; k++) begin mv[k] = 0; md[k] = 0; me[k] = 0; mw[k] = 0; end
    @(negedge clk);
    cycle();
    cycle();
    check("rst_tens", 8'(tens0), 8'd0);
    check("rst_done", 8'(done0), 8'd0);
    rst = 1'b0;

    // Up count to the ceiling with BCD carry, then saturate.
    do_ticks(10);
    check("carry_tens", 8'(tens0), 8'd1);
    check("carry_ones", 8'(ones0), 8'd0);
    do_ticks(49);
    check("up_tens", 8'(tens0), 8'd5);
    check("up_ones", 8'(ones0), 8'd9);
    check("up_expire", 8'(expire0), 8'd1);
    check("up_done", 8'(done0), 8'd1);
    do_ticks(1);
    check("sat_ones", 8'(ones0), 8'd9);
    check("sat_expire", 8'(expire0), 8'd0);

    // Down count from 05 with warning.
    count_down = 1'b1;
    do_load(4'd0, 4'd5);
    check("ld_warn", 8'(warn0), 8'd1);
    check("ld_done", 8'(done0), 8'd0);
    do_ticks(5);
    check("dn_ones", 8'(ones0), 8'd0);
    check("dn_expire", 8'(expire0), 8'd1);
    check("dn_warn", 8'(warn0), 8'd0);
    do_ticks(3);
    check("dn_hold", 8'(ones0), 8'd0);

    // Wrapping instance: 00 down -> 39, 39 up -> 00.
    do_load(4'd0, 4'd0);
    do_ticks(1);
    check("wrap_dn_tens", 8'(tens1), 8'd3);
    check("wrap_dn_ones", 8'(ones1), 8'd9);
    check("wrap_dn_exp", 8'(expire1), 8'd1);
    count_down = 1'b0;
    do_load(4'd3, 4'd9);
    do_ticks(1);
    check("wrap_up_tens", 8'(tens1), 8'd0);
    check("wrap_up_exp", 8'(expire1), 8'd1);
    check("wrap_done", 8'(done1), 8'd0);

    // Illegal and out-of-range loads clamp to the ceiling.
    do_load(4'hA, 4'd3);
    check("clampA_0", 8'({tens0, ones0}), 8'h59);
    check("clampA_1", 8'({tens1, ones1}), 8'h39);
    do_load(4'd7, 4'd5);
    check("clamp75_0", 8'({tens0, ones0}), 8'h59);

    // Pause holds the value but load still works; load beats tick.
    do_load(4'd2, 4'd3);
    pause = 1'b1;
    do_ticks(5);
    check("pause_hold", 8'({tens0, ones0}), 8'h23);
    tick = 1'b1;
    do_load(4'd1, 4'd2);
    check("pause_load", 8'({tens0, ones0}), 8'h12);
    pause = 1'b0;
    do_load(4'd3, 4'd0);
    tick = 1'b0;
    check("tick_load", 8'({tens0, ones0}), 8'h30);

    // Reset on a terminal tick wins.
    count_down = 1'b1;
    do_load(4'd0, 4'd1);
    tick = 1'b1; rst = 1'b1;
    cycle();
    tick = 1'b0; rst = 1'b0;
    check("rst_term_exp", 8'(expire0), 8'd0);
    check("rst_term_val", 8'({tens0, ones0}), 8'h00);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      tick      = ($urandom % 4) != 0;
      pause     = ($urandom % 8) == 0;
      load      = ($urandom % 20) == 0;
      rst       = ($urandom % 150) == 0;
      load_tens = 4'($urandom_range(0, 11));
      load_ones = 4'($urandom_range(0, 11));
      if (($urandom % 40) == 0) count_down = ~count_down;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
